vga_square_gen: RTL

Pixel-generation stage that sits directly downstream of the VGA sync generator. It consumes the pixel-enable tick, `pixel_x`, `pixel_y`, `video_on`, `hsync` and `vsync` from that generator. It draws a solid square that moves diagonally one step per frame and bounces off the screen edges over a flat background. It outputs 12-bit RGB together with hsync/vsync that are delayed to stay aligned with the RGB pipeline.

---
 rtl/vga_square_gen.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_square_gen.sv
// vga_square_gen
//
// Pixel-generation stage that follows the VGA sync generator. Draws a solid
// square that moves diagonally by VEL pixels per frame and bounces off the
// edges of the 640x480 visible area, over a flat background colour. RGB and
// the pass-through syncs leave through a matched 2-pixel pipeline, so the
// sync-to-colour relationship seen at the inputs is preserved at the outputs.
//
// Optional feature (compile-time macro):
//   VGA_BORDER_EN - draw a 1-pixel BORDER_COLOR frame around the visible area,
//                   taking priority over both the square and the background.
//
// Parameters:
//   SQ_SIZE      square edge length in pixels (1..479)
//   VEL          per-frame step on each axis in pixels (1..SQ_SIZE)
//   SQ_COLOR     square colour {R4,G4,B4}
//   BG_COLOR     background colour inside the visible area
//   BORDER_COLOR border colour (only with VGA_BORDER_EN)
//
// Ports:
//   clk       in   system clock, shared with the sync generator
//   reset     in   synchronous, active-high reset
//   pix_tick  in   one-clk pulse per pixel; all state advances only on it
//   pixel_x   in   current column 0..799
//   pixel_y   in   current row 0..524
//   video_on  in   high inside the 640x480 visible area
//   hsync_in  in   horizontal sync, polarity passed through unchanged
//   vsync_in  in   vertical sync, polarity passed through unchanged
//   rgb       out  12-bit pixel colour, 2 pixel ticks behind the inputs
//   hsync     out  hsync_in delayed to align with rgb
//   vsync     out  vsync_in delayed to align with rgb

module vga_square_gen #(
   parameter int unsigned SQ_SIZE      = 32,
   parameter int unsigned VEL          = 2,
   parameter logic [11:0] SQ_COLOR     = 12'hF00,
   parameter logic [11:0] BG_COLOR     = 12'h00F,
   parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_tick,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [11:0] rgb,
   output logic        hsync,
   output logic        vsync
);

   // Largest legal top-left coordinate on each axis.
   localparam logic [9:0]  X_MAX  = 10'(640 - SQ_SIZE);
   localparam logic [9:0]  Y_MAX  = 10'(480 - SQ_SIZE);
   localparam logic [10:0] VEL_W  = 11'(VEL);
   localparam logic [10:0] SIZE_W = 11'(SQ_SIZE);

   // Motion FSM: the encoding is {dir_x, dir_y}, 0 = increasing, 1 = decreasing.
   typedef enum logic [1:0] {
      StRightDown = 2'b00,
      StRightUp   = 2'b01,
      StLeftDown  = 2'b10,
      StLeftUp    = 2'b11
   } motion_e;

   motion_e     state_q, state_d;
   logic [9:0]  sq_x_q, sq_x_d;
   logic [9:0]  sq_y_q, sq_y_d;

   // Stage 1 registers
   logic        video_on_q;
   logic        hsync_s1_q;
   logic        vsync_s1_q;
   logic        in_sq_q;
   logic        on_border_q;

   logic        frame_tick;
   logic        dir_x, dir_y;
   logic        new_dir_x, new_dir_y;
   logic        in_sq;
   logic [10:0] step_x, step_y;

   // One step along an axis with clamping at either edge. Returns
   // {new_dir, new_pos}. Arithmetic is 11-bit so pos + VEL cannot wrap.
   function automatic logic [10:0] step(input logic [9:0] pos, input logic dir,
                                        input logic [9:0] lim);
      logic [10:0] sum;
      sum = {1'b0, pos} + VEL_W;
      if (!dir) begin
         if (sum > {1'b0, lim}) step = {1'b1, lim};
         else                   step = {1'b0, sum[9:0]};
      end else begin
         if ({1'b0, pos} < VEL_W) step = {1'b0, 10'd0};
         else                     step = {1'b1, pos - VEL_W[9:0]};
      end
   endfunction

   // Once per frame, during vertical blanking, so the square never tears.
   assign frame_tick = pix_tick && (pixel_x == 10'd0) && (pixel_y == 10'd480);

   assign step_x = step(sq_x_q, dir_x, X_MAX);
   assign step_y = step(sq_y_q, dir_y, Y_MAX);

   // ------------------------------------------------------------------
   // Motion FSM and position next-state
   // ------------------------------------------------------------------
   always_comb begin
      dir_x     = 1'b0;
      dir_y     = 1'b0;
      new_dir_x = 1'b0;
      new_dir_y = 1'b0;
      sq_x_d    = sq_x_q;
      sq_y_d    = sq_y_q;
      state_d   = state_q;

      unique case (state_q)
         StRightDown: begin dir_x = 1'b0; dir_y = 1'b0; end
         StRightUp:   begin dir_x = 1'b0; dir_y = 1'b1; end
         StLeftDown:  begin dir_x = 1'b1; dir_y = 1'b0; end
         StLeftUp:    begin dir_x = 1'b1; dir_y = 1'b1; end
      endcase

      new_dir_x = dir_x;
      new_dir_y = dir_y;

      if (frame_tick) begin
         // Axes are independent: a corner hit flips both directions at once.
         new_dir_x = step_x[10];
         new_dir_y = step_y[10];
         sq_x_d    = step_x[9:0];
         sq_y_d    = step_y[9:0];
      end

      unique case ({new_dir_x, new_dir_y})
         2'b00: state_d = StRightDown;
         2'b01: state_d = StRightUp;
         2'b10: state_d = StLeftDown;
         2'b11: state_d = StLeftUp;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StRightDown;
         sq_x_q  <= 10'd0;
         sq_y_q  <= 10'd0;
      end else if (pix_tick) begin
         state_q <= state_d;
         sq_x_q  <= sq_x_d;
         sq_y_q  <= sq_y_d;
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: hit test against the current square position
   // ------------------------------------------------------------------
   assign in_sq = ({1'b0, pixel_x} >= {1'b0, sq_x_q}) &&
                  ({1'b0, pixel_x} <  ({1'b0, sq_x_q} + SIZE_W)) &&
                  ({1'b0, pixel_y} >= {1'b0, sq_y_q}) &&
                  ({1'b0, pixel_y} <  ({1'b0, sq_y_q} + SIZE_W));

   always_ff @(posedge clk) begin
      if (reset) begin
         video_on_q <= 1'b0;
         hsync_s1_q <= 1'b0;
         vsync_s1_q <= 1'b0;
         in_sq_q    <= 1'b0;
      end else if (pix_tick) begin
         video_on_q <= video_on;
         hsync_s1_q <= hsync_in;
         vsync_s1_q <= vsync_in;
         in_sq_q    <= in_sq;
      end
   end

`ifdef VGA_BORDER_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         on_border_q <= 1'b0;
      end else if (pix_tick) begin
         on_border_q <= (pixel_x == 10'd0) || (pixel_x == 10'd639) ||
                        (pixel_y == 10'd0) || (pixel_y == 10'd479);
      end
   end
`else
   // Tied low so the colour mux below is the same text in both builds; the
   // border branch folds away entirely.
   assign on_border_q = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Stage 2: colour select and sync alignment
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb   <= 12'h000;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else if (pix_tick) begin
         hsync <= hsync_s1_q;
         vsync <= vsync_s1_q;
         if (!video_on_q)      rgb <= 12'h000;
         else if (on_border_q) rgb <= BORDER_COLOR;
         else if (in_sq_q)     rgb <= SQ_COLOR;
         else                  rgb <= BG_COLOR;
      end
   end

endmodule
